// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory answering MAR/MDR read/write strobes with a one-cycle mem_done.
// Define MEM_RANGE_CHECK_EN to drop/zero out-of-range accesses and raise sticky mem_err.
module mem_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 9,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [31:0]           MAR_addr,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [DATA_WIDTH-1:0] MDR_data,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_done,
    output logic                  mem_busy,
    output logic                  mem_err
);
    typedef enum logic [1:0] {IDLE, RD_WAIT, DONE} state_t;
    state_t state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx, addr;
    logic [3:0] cnt;
    logic is_rd, oor, oor_in, we;
    assign idx = MAR_addr[ADDR_WIDTH-1:0];
`ifdef MEM_RANGE_CHECK_EN
    assign oor_in = MAR_addr >= 32'(DEPTH);
`else
    logic unused_upper;
    assign unused_upper = ^MAR_addr[31:ADDR_WIDTH];
    assign oor_in = 1'b0;
`endif
    // the write commits on the accept edge, so any later read sees it
    assign we = state == IDLE && Write && !oor_in && !clear;
    always_ff @(posedge clock)
        if (we) mem[idx] <= MDR_data;
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            Mdatain  <= '0;
            mem_done <= 1'b0;
            mem_busy <= 1'b0;
            mem_err  <= 1'b0;
            cnt      <= '0;
            addr     <= '0;
            is_rd    <= 1'b0;
            oor      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    mem_done <= 1'b0;
                    mem_busy <= Read | Write;
                    is_rd    <= Read & ~Write;
                    oor      <= oor_in;
                    addr     <= idx;
                    cnt      <= 4'(READ_LATENCY - 1);
                    if (Read | Write) mem_err <= mem_err | oor_in;
                    if (Write) state <= DONE;
                    else if (Read) state <= (READ_LATENCY == 1) ? DONE : RD_WAIT;
                end
                RD_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE: begin
                    mem_done <= 1'b1;
                    state    <= IDLE;
                    if (is_rd) Mdatain <= oor ? '0 : mem[addr];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and randomized checks of mem_responder against an array reference model.
module tb_mem_responder;
    localparam int DW = 32, AW = 9, DEPTH = 512, RL = 2;
    logic clock = 1'b0, clear = 1'b0, Read = 1'b0, Write = 1'b0;
    logic [31:0] MAR_addr = '0;
    logic [DW-1:0] MDR_data = '0;
    logic [DW-1:0] Mdatain;
    logic mem_done, mem_busy, mem_err;
    int checks = 0, errors = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout = '0;

    mem_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clock(clock), .clear(clear), .MAR_addr(MAR_addr), .Read(Read), .Write(Write),
        .MDR_data(MDR_data), .Mdatain(Mdatain), .mem_done(mem_done), .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // called between edges; the request is accepted at the next rising edge
    task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [DW-1:0] data);
        int n;
        Read = rd; Write = wr; MAR_addr = addr; MDR_data = data;
        @(negedge clock);
        Read = 1'b0; Write = 1'b0;
        check("accept_busy", {31'd0, mem_busy}, 32'd1);
        check("accept_no_done", {31'd0, mem_done}, 32'd0);
        if (wr) ref_mem[addr[AW-1:0]] = data;
        else ref_dout = ref_mem[addr[AW-1:0]];
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!mem_done && n < 20);
        check(wr ? "wr_latency" : "rd_latency", n, wr ? 32'd1 : 32'(RL));
        check(wr ? "wr_dout_hold" : "rd_data", Mdatain, ref_dout);
        check("done_busy", {31'd0, mem_busy}, 32'd1);
    endtask

    initial begin
        int dones;
        // asynchronous reset pulsed mid-cycle
        @(posedge clock);
        #3 clear = 1'b1;
        #1;
        check("rst_dout", Mdatain, 32'd0);
        check("rst_done", {31'd0, mem_done}, 32'd0);
        check("rst_busy", {31'd0, mem_busy}, 32'd0);
        check("rst_err", {31'd0, mem_err}, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("idle_no_done", {31'd0, mem_done}, 32'd0);
            check("idle_busy", {31'd0, mem_busy}, 32'd0);
        end
        // write then read
        do_op(1'b0, 1'b1, 32'h55, 32'h0000_00A5);
        do_op(1'b1, 1'b0, 32'h55, 32'h0);
        check("rd_55", Mdatain, 32'h0000_00A5);
        // simultaneous read+write: write wins, Mdatain held
        do_op(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
        check("rw_hold", Mdatain, 32'h0000_00A5);
        do_op(1'b1, 1'b0, 32'h10, 32'h0);
        check("rd_10", Mdatain, 32'hDEAD_BEEF);
        // Read held for six edges while busy
        do_op(1'b0, 1'b1, 32'h20, 32'h1234_5678);
        Read = 1'b1; MAR_addr = 32'h20;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (i == 5) Read = 1'b0;
            dones += int'(mem_done);
            check("held_done", {31'd0, mem_done}, (i == 2 || i == 5) ? 32'd1 : 32'd0);
            check("held_busy", {31'd0, mem_busy}, 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            dones += int'(mem_done);
        end
        check("held_count", dones, 32'd2);
        check("held_idle_busy", {31'd0, mem_busy}, 32'd0);
        ref_dout = ref_mem[9'h20];
        check("held_data", Mdatain, ref_dout);
        // reset one cycle after a read accept
        @(negedge clock);
        Read = 1'b1; MAR_addr = 32'h55;
        @(negedge clock);
        Read = 1'b0;
        @(posedge clock);
        #2 clear = 1'b1;
        #1;
        ref_dout = '0;
        check("midrd_dout", Mdatain, ref_dout);
        check("midrd_busy", {31'd0, mem_busy}, 32'd0);
        @(negedge clock);
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("midrd_no_done", {31'd0, mem_done}, 32'd0);
        end
        do_op(1'b1, 1'b0, 32'h55, 32'h0);
        check("post_rst_55", Mdatain, 32'h0000_00A5);
        // address beyond DEPTH wraps onto word 0
        do_op(1'b0, 1'b1, 32'h0, 32'hCAFE_0000);
        do_op(1'b1, 1'b0, 32'h200, 32'h0);
        check("wrap_data", Mdatain, 32'hCAFE_0000);
        check("wrap_err", {31'd0, mem_err}, 32'd0);
        // randomized traffic over a pre-written window, with random upper address bits
        for (int i = 0; i < 16; i++) do_op(1'b0, 1'b1, 32'(i), $urandom);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            bit rd, wr;
            a = {$urandom_range(0, 255), 24'd0} | 32'($urandom_range(0, 15));
            wr = ($urandom_range(0, 2) == 0);
            rd = wr ? ($urandom_range(0, 1) == 1) : 1'b1;
            do_op(rd, wr, a, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end
        check("final_err", {31'd0, mem_err}, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Word-addressed synchronous memory that answers the datapath's memory strobes. It sits on the far side of MAR/MDR: it accepts `Read`/`Write` requests at the address presented from MAR and returns read data on `Mdatain` for MDR to latch. Completion is signalled with a one-cycle `mem_done` pulse, so a control sequencer can wait on memory instead of relying on fixed step timing.

## Interface
- `DATA_WIDTH`, 32, word width of memory and data ports
- `ADDR_WIDTH`, 9, number of index bits taken from `MAR_addr`
- `DEPTH`, 512, number of words; must be ≤ 2^ADDR_WIDTH
- `READ_LATENCY`, 2, number of clock edges from read accept to `mem_done` (legal range 1–15)

- `clock`  in  1  single clock; all state changes on its rising edge
- `clear`  in  1  reset, asynchronous, active-high
- `MAR_addr`  in  32  word address from MAR
- `Read`  in  1  read request strobe, level-sampled in IDLE
- `Write`  in  1  write request strobe, level-sampled in IDLE
- `MDR_data`  in  DATA_WIDTH  store data from MDR
- `Mdatain`  out  DATA_WIDTH  read data to MDR input mux
- `mem_done`  out  1  one-cycle completion pulse
- `mem_busy`  out  1  high while a request is in progress (not IDLE)
- `mem_err`  out  1  sticky out-of-range flag; constant 0 unless `MEM_RANGE_CHECK_EN` is defined

## Operation
- States: IDLE, RD_WAIT, DONE.
- IDLE with `Write`=1:
  - Store `MDR_data` at the addressed word on that edge.
  - Go to DONE.
  - `Write` wins when `Read` is also high; the read is dropped and is not queued.
- IDLE with `Read`=1 and `Write`=0:
  - Capture the index into an internal address register.
  - Load the wait counter with `READ_LATENCY`-1.
  - Go to RD_WAIT, or straight to DONE when `READ_LATENCY`=1.
- RD_WAIT: decrement the counter each edge. When it reaches 0, load `Mdatain` from memory at the captured index and go to DONE.
- DONE: `mem_done`=1 for exactly one cycle, then IDLE.
- `Read`/`Write` are ignored outside IDLE; no queuing.
- `Mdatain` holds its value until the next read completes. Writes never change `Mdatain`.
- Index = `MAR_addr[ADDR_WIDTH-1:0]`. Upper address bits are ignored unless `MEM_RANGE_CHECK_EN` is defined.
- Read-after-write to the same word returns the new data. The write commits before any later accept, so no hazard exists.
- `clear`:
  - Forces IDLE.
  - `Mdatain`=0, `mem_done`=0, `mem_busy`=0, `mem_err`=0, counter=0.
  - Memory array contents are NOT cleared.
  - A write already committed stays committed.
  - An in-flight read is abandoned and produces no `mem_done`.

## Timing
- Read accepted at edge k: `Mdatain` valid and `mem_done`=1 from edge k+`READ_LATENCY` until the next edge.
- Write accepted at edge k: `mem_done`=1 from edge k+1 until the next edge.
- Earliest next accept is the edge at which `mem_done` falls, i.e. back-to-back throughput is one request per `READ_LATENCY`+1 cycles for reads and 2 cycles for writes.
- `mem_busy` rises at the accept edge and falls with `mem_done`.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `MEM_RANGE_CHECK_EN` defined:
  - A request is out of range when `MAR_addr` ≥ `DEPTH`. It completes with normal timing.
  - An out-of-range write is dropped.
  - An out-of-range read returns 0 on `Mdatain`.
  - `mem_err` sets at the accept edge and stays high until `clear`.
- Not defined: the address always wraps to `MAR_addr[ADDR_WIDTH-1:0]` and `mem_err` is tied 0.

## Test plan
- Reset then idle: `clear` pulsed mid-cycle (asynchronous) → all outputs 0 immediately, `mem_busy`=0, no `mem_done` for 10 cycles.
- Write then read: write 0x0000_00A5 to address 0x55 → `mem_done` 1 cycle after accept. Read 0x55 → `Mdatain`=0x0000_00A5 with `mem_done` exactly 2 edges after accept.
- Simultaneous `Read`+`Write` at address 0x10 with data 0xDEAD_BEEF → write performed, single `mem_done` after 1 cycle, `Mdatain` unchanged. A following read of 0x10 returns 0xDEAD_BEEF.
- Strobes while busy: `Read` held high 6 cycles at address 0x20 → exactly two reads complete (accepts at cycles 0 and 3), `mem_busy` low only in the accept-ready cycles.
- Reset mid-read: `clear` asserted 1 cycle after a read accept → no `mem_done`, `Mdatain`=0. A previously written word still reads back correctly after reset.
- Range check: read at `MAR_addr`=0x200 → with `MEM_RANGE_CHECK_EN`, `Mdatain`=0 and `mem_err`=1 (sticky). Without it, the read returns the word at address 0x000 and `mem_err`=0.
